// File: rtl/mpuf_pkg.sv
// Shared types and helpers for the multi-PUF evaluation controller.
package mpuf_pkg;

   localparam int unsigned DEF_CW = 32;
   localparam int unsigned DEF_RW = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Cycles spent per vote round: clear pulse, settle wait, one sample cycle.
   function automatic int unsigned round_len(input int unsigned clr_cyc,
                                             input int unsigned settle_cyc);
      return clr_cyc + settle_cyc + 1;
   endfunction

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r = 0;
      int unsigned x = 1;
      while (x < v) begin
         x = x << 1;
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/mpuf_vote_acc.sv
// Per-bit vote counters; majority and disagreement flags reflect the count
// including the sample being accumulated this cycle.
module mpuf_vote_acc
   import mpuf_pkg::*;
#(
   parameter int unsigned RW    = DEF_RW,
   parameter int unsigned NVOTE = 3
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          start,
   input  logic          acc,
   input  logic [RW-1:0] o,
   output logic [RW-1:0] resp_c,
   output logic [RW-1:0] unstable_c
);

   localparam int unsigned CNW = clog2(NVOTE + 1);

   logic [CNW-1:0] cnt     [RW];
   logic [CNW-1:0] cnt_nxt [RW];

   always_comb begin
      for (int i = 0; i < int'(RW); i++) begin
         cnt_nxt[i]    = cnt[i] + (acc ? CNW'(o[i]) : CNW'(0));
         resp_c[i]     = cnt_nxt[i] > CNW'(NVOTE / 2);
         unstable_c[i] = (cnt_nxt[i] != CNW'(0)) && (cnt_nxt[i] != CNW'(NVOTE));
      end
   end

   always_ff @(posedge clk) begin
      if (clr || start) begin
         for (int i = 0; i < int'(RW); i++) cnt[i] <= '0;
      end else if (acc) begin
         for (int i = 0; i < int'(RW); i++) cnt[i] <= cnt_nxt[i];
      end
   end

endmodule

// File: rtl/mpuf_eval_ctrl.sv
// Sequences NVOTE clear/settle/sample rounds of the PUF array for one challenge
// and returns the majority response plus an unstable-bit mask.
module mpuf_eval_ctrl
   import mpuf_pkg::*;
#(
   parameter int unsigned CW         = DEF_CW,
   parameter int unsigned RW         = DEF_RW,
   parameter int unsigned CLR_CYC    = 2,
   parameter int unsigned SETTLE_CYC = 5,
   parameter int unsigned NVOTE      = 3
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          chal_valid,
   output logic          chal_ready,
   input  logic [CW-1:0] chal,
   output logic [CW-1:0] puf_c,
   output logic          puf_clear,
   output logic          puf_clr,
   input  logic [RW-1:0] puf_o,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [RW-1:0] resp,
   output logic [RW-1:0] unstable,
   output logic          busy
);

   localparam int unsigned PH_MAX = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
   localparam int unsigned PW     = (clog2(PH_MAX) < 1) ? 1 : clog2(PH_MAX);
   localparam int unsigned IW     = (clog2(NVOTE) < 1) ? 1 : clog2(NVOTE);

   if (NVOTE < 1 || (NVOTE % 2) == 0) begin : g_bad_nvote
      $error("mpuf_eval_ctrl: NVOTE must be odd and >= 1");
   end
   if (CLR_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_timing
      $error("mpuf_eval_ctrl: CLR_CYC and SETTLE_CYC must be >= 1");
   end

   state_t          state, state_nxt;
   logic [PW-1:0]   phase, phase_nxt;
   logic [IW-1:0]   rnd, rnd_nxt;
   logic            accept, vote_acc, load_resp, ready_q;
   logic [RW-1:0]   resp_c, unstable_c;

   mpuf_vote_acc #(.RW(RW), .NVOTE(NVOTE)) u_vote (
      .clk        (clk),
      .clr        (clr),
      .start      (accept),
      .acc        (vote_acc),
      .o          (puf_o),
      .resp_c     (resp_c),
      .unstable_c (unstable_c)
   );

   // ready is forced low while reset is asserted so no challenge slips in
   assign chal_ready = ready_q & ~clr;

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= ST_IDLE;
         phase <= '0;
         rnd   <= '0;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
         rnd   <= rnd_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      rnd_nxt   = rnd;
      accept    = 1'b0;
      vote_acc  = 1'b0;
      load_resp = 1'b0;
      case (state)
         ST_IDLE: begin
            if (chal_valid && chal_ready) begin
               accept    = 1'b1;
               phase_nxt = '0;
               rnd_nxt   = '0;
               state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (phase == PW'(CLR_CYC - 1)) begin
               phase_nxt = '0;
               state_nxt = ST_SETTLE;
            end else begin
               phase_nxt = phase + PW'(1);
            end
         end
         ST_SETTLE: begin
            if (phase == PW'(SETTLE_CYC - 1)) begin
               phase_nxt = '0;
               state_nxt = ST_SAMPLE;
            end else begin
               phase_nxt = phase + PW'(1);
            end
         end
         ST_SAMPLE: begin
            vote_acc = 1'b1;
            if (rnd == IW'(NVOTE - 1)) begin
               load_resp = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               rnd_nxt   = rnd + IW'(1);
               state_nxt = ST_CLEAR;
            end
         end
         ST_DONE: begin
            if (resp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (clr) begin
         ready_q    <= 1'b1;
         busy       <= 1'b0;
         puf_clear  <= 1'b0;
         puf_clr    <= 1'b0;
         resp_valid <= 1'b0;
         puf_c      <= '0;
         resp       <= '0;
         unstable   <= '0;
      end else begin
         ready_q    <= (state_nxt == ST_IDLE);
         busy       <= (state_nxt != ST_IDLE);
         puf_clear  <= (state_nxt == ST_CLEAR);
         puf_clr    <= (state_nxt == ST_CLEAR);
         resp_valid <= (state_nxt == ST_DONE);
         if (accept) puf_c <= chal;
         if (load_resp) begin
            resp     <= resp_c;
            unstable <= unstable_c;
         end
      end
   end

endmodule
